// File: rtl/factorial_sequencer.sv
// N! engine: iterates N..2 through a shared W x W -> 2W multiplier (two partial products per step).
// Optional overflow detection is compiled in with FACTORIAL_OVF_DETECT_EN.
module factorial_sequencer #(
  parameter int unsigned W = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           os,
  input  logic           oc,
  input  logic           oi,
  input  logic [W-1:0]   opr,
  output logic [1:0]     od,
  output logic [W-1:0]   rh,
  output logic [W-1:0]   rl,
  output logic           irq,
  output logic           mul_req,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_ack,
  input  logic [2*W-1:0] mul_p,
  output logic           ovf
);

  localparam int unsigned W2 = 2 * W;
`ifdef FACTORIAL_OVF_DETECT_EN
  localparam int unsigned PW = W2;
  localparam int unsigned SW = W2 + 1;
`else
  localparam int unsigned PW = W;
  localparam int unsigned SW = W2;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_LO, S_REQ_HI, S_ACC, S_DONE, S_FLUSH
  } state_t;

  state_t          state, state_nxt;
  logic            os_d;
  logic            start;
  logic [W2-1:0]   acc, acc_nxt, plo, plo_nxt;
  logic [PW-1:0]   phi, phi_nxt;
  logic [W-1:0]    cnt, cnt_nxt, cnt_dec;
  logic [W-1:0]    mul_a_nxt, mul_b_nxt;
  logic [1:0]      od_nxt;
  logic            irq_nxt, mul_req_nxt;
  logic [SW-1:0]   acc_sum;
  logic            ovf_q, ovf_nxt;

  assign start   = os & ~os_d & (state == S_IDLE);
  assign cnt_dec = cnt - W'(1);
  assign rh      = acc[W2-1:W];
  assign rl      = acc[W-1:0];

  // Recombine the two partial products: acc * cnt = plo + (phi << W)
`ifdef FACTORIAL_OVF_DETECT_EN
  assign acc_sum = {1'b0, plo} + {1'b0, phi[W-1:0], {W{1'b0}}};
  assign ovf     = ovf_q;
`else
  assign acc_sum = plo + {phi, {W{1'b0}}};
  assign ovf     = 1'b0;
  assign ovf_q   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    plo_nxt   = plo;
    phi_nxt   = phi;
    od_nxt    = od;
    ovf_nxt   = ovf_q;
    mul_a_nxt = mul_a;
    mul_b_nxt = mul_b;
    irq_nxt   = od[0] & oi;

    if (oc) begin
      // An outstanding multiply must still complete before returning to idle.
      acc_nxt   = W2'(1);
      cnt_nxt   = '0;
      od_nxt    = 2'b00;
      ovf_nxt   = 1'b0;
      irq_nxt   = 1'b0;
      state_nxt = (mul_req && !mul_ack) ? S_FLUSH : S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt_nxt   = opr;
            acc_nxt   = W2'(1);
            od_nxt    = 2'b10;
            ovf_nxt   = 1'b0;
            state_nxt = (opr <= W'(1)) ? S_DONE : S_REQ_LO;
          end
        end
        S_REQ_LO: begin
          if (mul_ack) begin
            plo_nxt   = mul_p;
            state_nxt = S_REQ_HI;
          end
        end
        S_REQ_HI: begin
          if (mul_ack) begin
            phi_nxt   = PW'(mul_p);
            state_nxt = S_ACC;
          end
        end
        S_ACC: begin
          acc_nxt   = acc_sum[W2-1:0];
          cnt_nxt   = cnt_dec;
`ifdef FACTORIAL_OVF_DETECT_EN
          ovf_nxt   = ovf_q | (phi[W2-1:W] != '0) | acc_sum[W2];
`endif
          state_nxt = (cnt_dec <= W'(1)) ? S_DONE : S_REQ_LO;
        end
        S_DONE: begin
          od_nxt    = {ovf_q, 1'b1};
          state_nxt = S_IDLE;
        end
        S_FLUSH: begin
          if (mul_ack) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    mul_req_nxt = (state_nxt == S_REQ_LO) || (state_nxt == S_REQ_HI) ||
                  (state_nxt == S_FLUSH);
    if (state_nxt == S_REQ_LO) begin
      mul_a_nxt = acc_nxt[W-1:0];
      mul_b_nxt = cnt_nxt;
    end else if (state_nxt == S_REQ_HI) begin
      mul_a_nxt = acc_nxt[W2-1:W];
      mul_b_nxt = cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      os_d    <= 1'b0;
      acc     <= W2'(1);
      cnt     <= '0;
      plo     <= '0;
      phi     <= '0;
      od      <= 2'b00;
      irq     <= 1'b0;
      mul_req <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
    end else begin
      state   <= state_nxt;
      os_d    <= os;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      plo     <= plo_nxt;
      phi     <= phi_nxt;
      od      <= od_nxt;
      irq     <= irq_nxt;
      mul_req <= mul_req_nxt;
      mul_a   <= mul_a_nxt;
      mul_b   <= mul_b_nxt;
    end
  end

`ifdef FACTORIAL_OVF_DETECT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_nxt;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ovf_nxt;
`endif

endmodule
